regfile_cmd_sequencer: RTL

//  Multi-cycle controller that owns all ports of the 8x8 register file (r0 reads as zero).

---
 rtl/regfile_cmd_sequencer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/regfile_cmd_sequencer.sv
// rtl/regfile_cmd_sequencer.sv - ALU command sequencer owning the 8x8 register file ports
//
// Ports:
//   Clk, Rst_n                     clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            command handshake; ready only in IDLE
//   cmd_op/cmd_rd/cmd_rs1/cmd_rs2  opcode, destination and source registers
//   cmd_imm                        immediate for LDI
//   rsp_valid/rsp_ready            response handshake; response held until accepted
//   rsp_data/rsp_zero/rsp_carry    result, zero flag, ADD carry / SUB borrow
//   rf_WEN/rf_RW/rf_busW           register file write port
//   rf_RX/rf_RY/rf_busX/rf_busY    register file read ports (combinational read data)
//   busy                           high in every state except IDLE
module regfile_cmd_sequencer #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_rs1,
    input  logic [AW-1:0] cmd_rs2,
    input  logic [DW-1:0] cmd_imm,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_zero,
    output logic          rsp_carry,
    output logic          rf_WEN,
    output logic [AW-1:0] rf_RW,
    output logic [DW-1:0] rf_busW,
    output logic [AW-1:0] rf_RX,
    output logic [AW-1:0] rf_RY,
    input  logic [DW-1:0] rf_busX,
    input  logic [DW-1:0] rf_busY,
    output logic          busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_LDI = 3'b110;
    localparam logic [2:0] OP_RD  = 3'b111;

    logic [2:0]    state;
    logic [2:0]    op_q;
    logic [AW-1:0] rd_q;
    logic [AW-1:0] rs1_q;
    logic [AW-1:0] rs2_q;
    logic [DW-1:0] imm_q;
    logic [DW-1:0] x_q;
    logic [DW-1:0] y_q;
    logic [DW-1:0] result_q;
    logic          zero_q;
    logic          carry_q;

    logic [DW-1:0] alu_result;
    logic          alu_carry;
    logic [DW:0]   add_wide;

    assign add_wide = {1'b0, x_q} + {1'b0, y_q};

    always_comb begin
        alu_result = '0;
        alu_carry  = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_result = add_wide[DW-1:0];
                alu_carry  = add_wide[DW];
            end
            OP_SUB: begin
                alu_result = x_q - y_q;
                alu_carry  = (x_q < y_q);
            end
            OP_AND: alu_result = x_q & y_q;
            OP_OR:  alu_result = x_q | y_q;
            OP_XOR: alu_result = x_q ^ y_q;
            OP_SHL: alu_result = x_q << y_q[2:0];
            OP_LDI: alu_result = imm_q;
            OP_RD:  alu_result = x_q;
            default: alu_result = '0;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= S_IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            imm_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q  <= cmd_op;
                        rd_q  <= cmd_rd;
                        rs1_q <= cmd_rs1;
                        rs2_q <= cmd_rs2;
                        imm_q <= cmd_imm;
                        state <= S_READ;
                    end
                end
                S_READ: begin
                    x_q   <= rf_busX;
                    y_q   <= rf_busY;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    result_q <= alu_result;
                    zero_q   <= (alu_result == '0);
                    carry_q  <= alu_carry;
                    state    <= S_WRITE;
                end
                S_WRITE: state <= S_RESP;
                S_RESP: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // All outputs decode straight from state so an asynchronous reset
    // clears them (including rf_WEN) without waiting for a clock edge.
    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign rsp_data  = (state == S_RESP) ? result_q : '0;
    assign rsp_zero  = (state == S_RESP) && zero_q;
    assign rsp_carry = (state == S_RESP) && carry_q;

    assign rf_RX   = (state == S_READ) ? rs1_q : '0;
    assign rf_RY   = (state == S_READ) ? rs2_q : '0;
    assign rf_RW   = (state == S_WRITE) ? rd_q : '0;
    assign rf_busW = (state == S_WRITE) ? result_q : '0;
    // RD only returns a value, and r0 is hard-wired zero, so neither writes.
    assign rf_WEN  = (state == S_WRITE) && (op_q != OP_RD) && (rd_q != '0);

endmodule
